// File: rtl/crypto_pkg.sv
// crypto_pkg: shared constants and FSM state type for the crypto scheduler.
package crypto_pkg;
  localparam int BYTE_W      = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/crypto_rr_arb.sv
// crypto_rr_arb: one-hot round-robin grant, searching upward from pointer+1.
module crypto_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant
);
  logic found;

  // Offset k=1 is the highest priority slot, k=N wraps back to pointer itself.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(pointer) + k) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/crypto_sched.sv
// crypto_sched: round-robin scheduler feeding one shared encryption pipeline.
// Optional per-requester byte counters are enabled by CRYPTO_SCHED_STATS_EN.
module crypto_sched
  import crypto_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         pipe_data_in,
  input  logic [BYTE_W-1:0]         pipe_data_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [BYTE_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      idle
`ifdef CRYPTO_SCHED_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*16-1:0]     stat_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);

  state_t               state, next_state;
  logic [IW-1:0]        last_grant;
  logic [NUM_REQ-1:0]   grant;
  logic [LATENCY-1:0]   tag_valid;
  logic [IW-1:0]        tag_id [LATENCY];
  logic                 transfer;
  logic [IW-1:0]        grant_id;
  logic [BYTE_W-1:0]    grant_byte;
  logic [NUM_REQ-1:0]   rsp_next;

  crypto_rr_arb #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .pointer (last_grant),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Grants are only exposed in RUN; DRAIN waits for the tag pipe to empty.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      IDLE: if (en) next_state = RUN;
      RUN: begin
        req_ready = grant;
        if (!en) next_state = DRAIN;
      end
      DRAIN: begin
        if (en)        next_state = RUN;
        else if (!busy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    grant_id   = '0;
    grant_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        grant_id   = IW'(i);
        grant_byte = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    rsp_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_next[i] = tag_valid[LATENCY-1] && (tag_id[LATENCY-1] == IW'(i));
    end
  end

  // The response strobe is registered off the last tag stage so it lines up
  // with pipe_data_out, which becomes valid LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant   <= IW'(NUM_REQ - 1);
      pipe_data_in <= '0;
      tag_valid    <= '0;
      rsp_valid    <= '0;
      for (int s = 0; s < LATENCY; s++) tag_id[s] <= '0;
    end else begin
      rsp_valid    <= rsp_next;
      tag_valid[0] <= transfer;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      pipe_data_in <= transfer ? grant_byte : '0;
      if (transfer) last_grant <= grant_id;
    end
  end

  assign rsp_data = pipe_data_out;
  assign busy     = |tag_valid;
  assign idle     = (state == IDLE);

`ifdef CRYPTO_SCHED_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // Clear wins over a same-cycle transfer; counts saturate at 16'hFFFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (stat_cnt[i] != 16'hFFFF))
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_count[g*16 +: 16] = stat_cnt[g];
  end
`endif
endmodule

// File: doc/crypto_sched.md
CRYPTO_SCHED -- requirements
Module: crypto_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one encryption pipeline (range 2..8).
REQ-002 The block SHALL have parameter LATENCY, default 5, meaning the cycles from pipe_data_in registered to pipe_data_out valid.
REQ-003 clk  input  1  single clock; all state rises on the posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scheduler enable; low stops new grants and drains in-flight bytes.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  NUM_REQ*8  per-requester plaintext byte; requester i uses bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 pipe_data_in  output  8  byte driven into the encryption pipeline.
REQ-010 pipe_data_out  input  8  ciphertext byte from the encryption pipeline.
REQ-011 rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking rsp_data for requester i; no backpressure.
REQ-012 rsp_data  output  8  ciphertext byte, equal to pipe_data_out.
REQ-013 busy  output  1  high while any tag is in flight.
REQ-014 idle  output  1  high only in state IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE->RUN on en=1.
- RUN->DRAIN on en=0.
- DRAIN->IDLE when the tag pipe is empty.
- DRAIN->RUN on en=1.
REQ-016 req_ready SHALL be all-zero outside RUN, and in RUN SHALL be combinational from req_valid and the round-robin pointer.
REQ-017 The arbiter SHALL grant the first valid requester searching upward, modulo NUM_REQ, from last_grant+1, with at most one grant per cycle.
REQ-018 last_grant SHALL update only on a completed transfer, never on an idle cycle.
REQ-019 On the accepting edge N, pipe_data_in SHALL register the granted byte, and a tag {valid=1, id} SHALL enter a LATENCY-deep shift register.
REQ-020 On cycles without a transfer, pipe_data_in SHALL register 8'h00 and an invalid tag SHALL enter the shift register.
REQ-021 rsp_valid[id] SHALL be high exactly between edges N+LATENCY and N+LATENCY+1, with rsp_data = pipe_data_out.
REQ-022 Back-to-back transfers SHALL sustain one byte per cycle with responses in accept order.
REQ-023 busy SHALL equal the OR of all tag valid bits.
REQ-024 en falling in the same cycle as a transfer SHALL still complete that transfer, and the FSM SHALL enter DRAIN on that edge.

Reset
REQ-025 While rst=0, the block SHALL hold:
- state=IDLE, last_grant=NUM_REQ-1, all tags invalid;
- pipe_data_in=0, req_ready=0, rsp_valid=0;
- busy=0, idle=1.
REQ-026 Reset asserted mid-operation SHALL drop in-flight responses, so no rsp_valid pulse occurs after reset release for pre-reset bytes.

Configuration
REQ-027 With macro CRYPTO_SCHED_STATS_EN defined, the block SHALL add:
- input stat_clr (1 bit);
- output stat_count (NUM_REQ*16 bits);
- one 16-bit saturating count of accepted bytes per requester, cleared by reset or stat_clr;
- stat_clr in the same cycle as a transfer yields a count of 0.
REQ-028 Without CRYPTO_SCHED_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package crypto_pkg SHALL hold the byte width constant, the NUM_REQ and LATENCY defaults, and the FSM state enum.
REQ-030 Round-robin grant logic SHALL be a sub-module crypto_rr_arb (inputs: req, pointer; output: one-hot grant).

Verification
REQ-031 The bench SHALL model the pipeline as a LATENCY-deep XOR-0x5A delay line and cover these scenarios:
- Single transfer: en=1, req_valid=0001, req_data[0]=8'h3C accepted at edge N -> rsp_valid=0001 with rsp_data=8'h66 during cycle N+5..N+6.
- Fairness: all four requesters valid continuously -> grants 0,1,2,3,0,... and responses in the same order, one per cycle.
- Drain: en dropped with 3 bytes in flight -> req_ready=0 immediately, exactly 3 responses follow, then idle=1 and busy=0.
- Reset mid-run: rst=0 pulsed with 4 bytes in flight -> no rsp_valid after release, pipe_data_in=0, last_grant=3.
- Sparse requests: requesters 1 and 3 only -> grants alternate 1,3,1,3; no pointer advance on idle cycles.
- With CRYPTO_SCHED_STATS_EN: 70000 transfers from requester 2 -> stat_count[47:32]=16'hFFFF; stat_clr -> 0.
